// File: rtl/dual_rail_receiver.sv
// Dual-rail (1-of-2 per bit) 4-phase receiver for a 2-bit word {A,B} with a ready/valid output.
// Optional sequence checker enabled by defining DUAL_RAIL_SEQ_CHECK_EN.
module dual_rail_receiver (
  input  logic       clk,
  input  logic       rst,
  input  logic       a0,
  input  logic       a1,
  input  logic       b0,
  input  logic       b1,
  output logic       ack,
  output logic [1:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] token_count,
  output logic       err_illegal,
  output logic       seq_err
);

  typedef enum logic [1:0] {
    WAIT_DATA = 2'd0,
    PRESENT   = 2'd1,
    ACK_HI    = 2'd2,
    ACK_LO    = 2'd3
  } state_t;

  state_t state, state_next;

  // Rail vectors are packed as {a1, a0, b1, b0}.
  logic [3:0] rails_meta;
  logic [3:0] rails_sync;
  logic [3:0] rails_prev;

  logic a_valid, b_valid, a_illegal, b_illegal;
  logic rails_null, word_stable, accept, capture;
  logic [1:0] word;

  // NOTE: synchronizer flops are reset so no stale codeword survives a reset;
  // all sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      rails_meta <= 4'b0000;
      rails_sync <= 4'b0000;
      rails_prev <= 4'b0000;
    end else begin
      rails_meta <= {a1, a0, b1, b0};
      rails_sync <= rails_meta;
      rails_prev <= rails_sync;
    end
  end

  assign a_valid     = rails_sync[3] ^ rails_sync[2];
  assign b_valid     = rails_sync[1] ^ rails_sync[0];
  assign a_illegal   = rails_sync[3] & rails_sync[2];
  assign b_illegal   = rails_sync[1] & rails_sync[0];
  assign word        = {rails_sync[3], rails_sync[1]};
  assign rails_null  = (rails_sync == 4'b0000);

  // A word is only trusted once the same complete codeword is seen on two
  // consecutive synchronized samples; this filters skew between rails.
  assign word_stable = a_valid && b_valid && (rails_sync == rails_prev);

  assign out_valid   = (state == PRESENT);
  assign ack         = (state == ACK_HI);
  assign accept      = out_valid && out_ready;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      WAIT_DATA: begin
        if (word_stable) begin
          capture    = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (accept) state_next = ACK_HI;
      end
      ACK_HI: begin
        if (rails_null) state_next = ACK_LO;
      end
      ACK_LO: begin
        state_next = WAIT_DATA;
      end
      default: state_next = WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_DATA;
      out_data    <= 2'b00;
      token_count <= 8'd0;
      err_illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (capture) out_data <= word;
      if (accept) token_count <= token_count + 8'd1;
      if (a_illegal || b_illegal) err_illegal <= 1'b1;
    end
  end

`ifdef DUAL_RAIL_SEQ_CHECK_EN
  logic       have_prev;
  logic [1:0] prev_token;
  logic       seq_err_q;

  // Tokens are expected to count 0,1,2,3,0,...; the first one after reset
  // only seeds the reference.
  always_ff @(posedge clk) begin
    if (rst) begin
      have_prev  <= 1'b0;
      prev_token <= 2'b00;
      seq_err_q  <= 1'b0;
    end else if (accept) begin
      have_prev  <= 1'b1;
      prev_token <= out_data;
      if (have_prev && (out_data != prev_token + 2'd1)) seq_err_q <= 1'b1;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_dual_rail_receiver.sv
// Directed self-checking bench for dual_rail_receiver: handshake, backpressure,
// illegal codes, counter wrap, sequence checking and reset mid-handshake.
module tb_dual_rail_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       a0, a1, b0, b1;
  logic       ack;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] token_count;
  logic       err_illegal;
  logic       seq_err;

  int checks   = 0;
  int failures = 0;

`ifdef DUAL_RAIL_SEQ_CHECK_EN
  localparam logic SEQ_EN = 1'b1;
`else
  localparam logic SEQ_EN = 1'b0;
`endif

  dual_rail_receiver dut (
    .clk         (clk),
    .rst         (rst),
    .a0          (a0),
    .a1          (a1),
    .b0          (b0),
    .b1          (b1),
    .ack         (ack),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .token_count (token_count),
    .err_illegal (err_illegal),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, then settle 1ns so outputs are sampled off-edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [1:0] w);
    a1 = w[1]; a0 = ~w[1];
    b1 = w[0]; b0 = ~w[0];
  endtask

  task automatic drive_null();
    {a1, a0, b1, b0} = 4'b0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // One complete 4-phase handshake with out_ready high; every wait is bounded.
  task automatic handshake(input logic [1:0] w);
    int n;
    out_ready = 1'b1;
    drive_word(w);
    n = 0;
    while (!out_valid && n < 12) begin step(1); n++; end
    check("hs_valid", {7'd0, out_valid}, 8'd1);
    check("hs_data", {6'd0, out_data}, {6'd0, w});
    step(1);
    check("hs_ack_rise", {7'd0, ack}, 8'd1);
    drive_null();
    n = 0;
    while (ack && n < 12) begin step(1); n++; end
    check("hs_ack_fall", {7'd0, ack}, 8'd0);
    step(1);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive_null();
    step(3);

    // Reset state
    check("rst_ack", {7'd0, ack}, 8'd0);
    check("rst_valid", {7'd0, out_valid}, 8'd0);
    check("rst_data", {6'd0, out_data}, 8'd0);
    check("rst_count", token_count, 8'd0);
    check("rst_err", {7'd0, err_illegal}, 8'd0);
    check("rst_seq", {7'd0, seq_err}, 8'd0);
    rst = 1'b0;
    step(1);

    // Basic token A=1,B=0 with out_ready high: exact latency and one-cycle valid pulse
    out_ready = 1'b1;
    drive_word(2'b10);
    step(3);
    check("t1_not_yet", {7'd0, out_valid}, 8'd0);
    step(1);
    check("t1_valid", {7'd0, out_valid}, 8'd1);
    check("t1_data", {6'd0, out_data}, 8'h02);
    check("t1_ack_low", {7'd0, ack}, 8'd0);
    step(1);
    check("t1_valid_drop", {7'd0, out_valid}, 8'd0);
    check("t1_ack_high", {7'd0, ack}, 8'd1);
    check("t1_count", token_count, 8'd1);
    drive_null();
    step(2);
    check("t1_ack_hold", {7'd0, ack}, 8'd1);
    step(1);
    check("t1_ack_fall", {7'd0, ack}, 8'd0);
    step(1);

    // Partial codeword (A valid, B NULL) must not be captured
    a1 = 1'b1;
    step(8);
    check("partial_no_cap", {7'd0, out_valid}, 8'd0);
    check("partial_count", token_count, 8'd1);
    drive_null();
    step(4);

    // Codeword changing after one sample: 01 only lives one cycle, 10 is captured
    out_ready = 1'b0;
    drive_word(2'b01);
    step(1);
    drive_word(2'b10);
    step(3);
    check("chg_not_yet", {7'd0, out_valid}, 8'd0);
    step(1);
    check("chg_valid", {7'd0, out_valid}, 8'd1);
    check("chg_data", {6'd0, out_data}, 8'h02);
    out_ready = 1'b1;
    step(1);
    check("chg_count", token_count, 8'd2);
    drive_null();
    step(4);

    // Backpressure: codeword 11 held for 10 cycles with out_ready low
    out_ready = 1'b0;
    drive_word(2'b11);
    step(4);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {7'd0, out_valid}, 8'd1);
      check("bp_data", {6'd0, out_data}, 8'h03);
      check("bp_ack", {7'd0, ack}, 8'd0);
      step(1);
    end
    out_ready = 1'b1;
    step(1);
    check("bp_ack_rise", {7'd0, ack}, 8'd1);
    check("bp_count", token_count, 8'd3);
    drive_null();
    step(4);
    check("bp_ack_fall", {7'd0, ack}, 8'd0);

    // Illegal pair a0=a1=1 (B valid) for 3 cycles
    check("ill_err_before", {7'd0, err_illegal}, 8'd0);
    {a1, a0, b1, b0} = 4'b1101;
    step(3);
    check("ill_err_set", {7'd0, err_illegal}, 8'd1);
    drive_null();
    step(6);
    check("ill_err_sticky", {7'd0, err_illegal}, 8'd1);
    check("ill_no_cap", {7'd0, out_valid}, 8'd0);
    check("ill_count", token_count, 8'd3);

    // Counter wrap: 256 handshakes from reset -> 0, then one more -> 1
    do_reset();
    check("wrap_err_cleared", {7'd0, err_illegal}, 8'd0);
    for (int i = 0; i < 256; i++) handshake(i[1:0]);
    check("wrap_256", token_count, 8'd0);
    handshake(2'b00);
    check("wrap_257", token_count, 8'd1);
    check("wrap_seq_ok", {7'd0, seq_err}, 8'd0);

    // Sequence checker: in-order run, then a skip (01 -> 11)
    do_reset();
    handshake(2'b00);
    handshake(2'b01);
    handshake(2'b10);
    handshake(2'b11);
    handshake(2'b00);
    check("seq_in_order", {7'd0, seq_err}, 8'd0);
    do_reset();
    handshake(2'b00);
    handshake(2'b01);
    check("seq_before_skip", {7'd0, seq_err}, 8'd0);
    handshake(2'b11);
    check("seq_skip", {7'd0, seq_err}, {7'd0, SEQ_EN});

    // Reset while in ACK_HI with rails holding 01
    do_reset();
    out_ready = 1'b1;
    drive_word(2'b01);
    step(5);
    check("mid_ack_high", {7'd0, ack}, 8'd1);
    check("mid_count", token_count, 8'd1);
    rst = 1'b1;
    out_ready = 1'b0;
    step(1);
    check("mid_rst_ack", {7'd0, ack}, 8'd0);
    check("mid_rst_count", token_count, 8'd0);
    check("mid_rst_seq", {7'd0, seq_err}, 8'd0);
    rst = 1'b0;
    step(3);
    check("recap_not_yet", {7'd0, out_valid}, 8'd0);
    step(1);
    check("recap_valid", {7'd0, out_valid}, 8'd1);
    check("recap_data", {6'd0, out_data}, 8'h01);
    out_ready = 1'b1;
    step(1);
    check("recap_count", token_count, 8'd1);
    drive_null();
    step(4);
    check("recap_ack_fall", {7'd0, ack}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
